// File: rtl/uart_modem_flowctrl.sv
// Modem-line synchroniser/debouncer with MSR status, sticky deltas, 16550-style loopback
// and automatic RTS/CTS hardware flow control.
module uart_modem_flowctrl #(
    parameter int NrSyncStages   = 2,
    parameter int DebounceCycles = 4,
    parameter int FifoDepth      = 16,
    parameter int RtsOffLevel    = 14,
    parameter int RtsOnLevel     = 8,
    localparam int LevelW        = $clog2(FifoDepth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cts_ni,
    input  logic              dsr_ni,
    input  logic              ri_ni,
    input  logic              cd_ni,
    output logic              rts_no,
    output logic              dtr_no,
    input  logic [5:0]        mcr_i,
    input  logic              msr_rd_i,
    input  logic              msi_en_i,
    input  logic [LevelW-1:0] rx_level_i,
    output logic [7:0]        msr_o,
    output logic              tx_allow_o,
    output logic              msi_irq_o
);

    typedef enum logic [0:0] {RTS_ON = 1'b0, RTS_OFF = 1'b1} flow_state_e;

    localparam logic [LevelW-1:0] OffLvl = LevelW'(RtsOffLevel);
    localparam logic [LevelW-1:0] OnLvl  = LevelW'(RtsOnLevel);

    if (NrSyncStages < 2 || !(RtsOnLevel < RtsOffLevel && RtsOffLevel <= FifoDepth)) begin : g_param_err
        $error("uart_modem_flowctrl: illegal parameter combination");
    end

    // Line vectors are ordered {cd, ri, dsr, cts} to line up with the MSR layout.
    logic [3:0]  pins_s;
    logic [3:0]  sync_r [NrSyncStages];
    logic [3:0]  filt_s;
    logic [3:0]  status_r;
    logic [3:0]  status_nxt_s;
    logic [3:0]  set_s;
    logic [3:0]  delta_r;
    logic        irq_r;
    logic        rts_n_r;
    logic        rts_n_nxt_s;
    logic        dtr_n_r;
    flow_state_e state_r;
    flow_state_e state_nxt_s;

    logic mcr_afe_s, mcr_loop_s, mcr_out2_s, mcr_out1_s, mcr_rts_s, mcr_dtr_s;
    assign {mcr_afe_s, mcr_loop_s, mcr_out2_s, mcr_out1_s, mcr_rts_s, mcr_dtr_s} = mcr_i;
    assign pins_s = {cd_ni, ri_ni, dsr_ni, cts_ni};

    // Synchroniser chain for the asynchronous modem pins; idles at the inactive (high) level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < NrSyncStages; s++) sync_r[s] <= 4'hF;
        end else begin
            sync_r[0] <= pins_s;
            for (int s = 1; s < NrSyncStages; s++) sync_r[s] <= sync_r[s-1];
        end
    end

    if (DebounceCycles == 0) begin : g_no_deb
        assign filt_s = sync_r[NrSyncStages-1];
    end else begin : g_deb
        localparam int CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
        localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);
        localparam logic [CntW-1:0] CntOne  = CntW'(1);
        logic [CntW-1:0] cnt_r [4];
        logic [3:0]      filt_r;

        // Per-line debounce: the filtered level follows only after DebounceCycles stable samples.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                filt_r <= 4'hF;
                for (int i = 0; i < 4; i++) cnt_r[i] <= {CntW{1'b0}};
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (sync_r[NrSyncStages-1][i] != filt_r[i]) begin
                        if (cnt_r[i] == CntLast) begin
                            filt_r[i] <= sync_r[NrSyncStages-1][i];
                            cnt_r[i]  <= {CntW{1'b0}};
                        end else begin
                            cnt_r[i]  <= cnt_r[i] + CntOne;
                        end
                    end else begin
                        cnt_r[i] <= {CntW{1'b0}};
                    end
                end
            end
        end
        assign filt_s = filt_r;
    end

    // Next status source (pins or loopback MCR bits) and the sticky-bit set events it implies.
    always_comb begin
        status_nxt_s = ~filt_s;
        if (mcr_loop_s) begin
            status_nxt_s = {mcr_out2_s, mcr_out1_s, mcr_dtr_s, mcr_rts_s};
        end else begin
            status_nxt_s = ~filt_s;
        end
        set_s = {status_nxt_s[3] ^ status_r[3],
                 status_r[2] & ~status_nxt_s[2],
                 status_nxt_s[1] ^ status_r[1],
                 status_nxt_s[0] ^ status_r[0]};
    end

    // MSR status/sticky registers and the modem-status interrupt; a set beats a same-cycle read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            status_r <= 4'h0;
            delta_r  <= 4'h0;
            irq_r    <= 1'b0;
        end else begin
            status_r <= status_nxt_s;
            delta_r  <= set_s | (delta_r & {4{~msr_rd_i}});
            irq_r    <= msi_en_i & (|delta_r);
        end
    end

    // Flow-control state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= RTS_ON;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Flow-control next state with RX-level hysteresis, and the RTS pin value it implies.
    always_comb begin
        state_nxt_s = state_r;
        rts_n_nxt_s = 1'b1;
        if (mcr_afe_s && mcr_rts_s) begin
            case (state_r)
                RTS_ON: begin
                    if (rx_level_i >= OffLvl) state_nxt_s = RTS_OFF;
                    else                      state_nxt_s = RTS_ON;
                end
                RTS_OFF: begin
                    if (rx_level_i <= OnLvl) state_nxt_s = RTS_ON;
                    else                     state_nxt_s = RTS_OFF;
                end
                default: state_nxt_s = RTS_ON;
            endcase
        end else begin
            state_nxt_s = RTS_ON;
        end
        if (mcr_loop_s) begin
            rts_n_nxt_s = 1'b1;
        end else if (state_nxt_s == RTS_OFF) begin
            rts_n_nxt_s = 1'b1;
        end else begin
            rts_n_nxt_s = ~mcr_rts_s;
        end
    end

    // Registered modem output pins; loopback parks both at the inactive level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rts_n_r <= 1'b1;
            dtr_n_r <= 1'b1;
        end else begin
            rts_n_r <= rts_n_nxt_s;
            dtr_n_r <= mcr_loop_s | ~mcr_dtr_s;
        end
    end

    assign rts_no     = rts_n_r;
    assign dtr_no     = dtr_n_r;
    assign msr_o      = {status_r, delta_r};
    assign msi_irq_o  = irq_r;
    assign tx_allow_o = ~mcr_afe_s | status_r[0];

endmodule

// File: tb/tb_uart_modem_flowctrl.sv
// Directed self-checking bench for uart_modem_flowctrl with hand-computed expected values.
module tb_uart_modem_flowctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cts_n, dsr_n, ri_n, cd_n;
    logic       rts_n, dtr_n;
    logic [5:0] mcr;
    logic       msr_rd, msi_en;
    logic [4:0] rx_level;
    logic [7:0] msr;
    logic       tx_allow, irq;

    int errors = 0;
    int checks = 0;

    uart_modem_flowctrl dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cts_ni     (cts_n),
        .dsr_ni     (dsr_n),
        .ri_ni      (ri_n),
        .cd_ni      (cd_n),
        .rts_no     (rts_n),
        .dtr_no     (dtr_n),
        .mcr_i      (mcr),
        .msr_rd_i   (msr_rd),
        .msi_en_i   (msi_en),
        .rx_level_i (rx_level),
        .msr_o      (msr),
        .tx_allow_o (tx_allow),
        .msi_irq_o  (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic read_msr();
        msr_rd = 1'b1;
        tick(1);
        msr_rd = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cts_n = 1'b0; dsr_n = 1'b0; ri_n = 1'b0; cd_n = 1'b0;
        mcr = 6'b000000; msr_rd = 1'b0; msi_en = 1'b0; rx_level = 5'd0;
        tick(3);
        check("rst_msr", msr, 8'h00);
        check("rst_rts", {7'd0, rts_n}, 8'h01);
        check("rst_dtr", {7'd0, dtr_n}, 8'h01);
        check("rst_irq", {7'd0, irq}, 8'h00);

        // Pins low from reset: status appears exactly 2+4+1 cycles after release.
        rst = 1'b0;
        tick(6);
        check("lat_before", msr, 8'h00);
        tick(1);
        check("lat_at", msr, 8'hFB);
        read_msr();
        check("rd_clear", msr, 8'hF0);

        // 3-cycle glitch is filtered out.
        cts_n = 1'b1;
        tick(3);
        cts_n = 1'b0;
        tick(10);
        check("glitch", msr, 8'hF0);

        // Held change reaches status with full latency.
        cts_n = 1'b1;
        tick(6);
        check("cts_before", msr, 8'hF0);
        tick(1);
        check("cts_held", msr, 8'hE1);

        // Read and a new dsr event in the same cycle: d_cts clears, d_dsr kept.
        dsr_n = 1'b1;
        tick(6);
        check("pre_same", msr, 8'hE1);
        read_msr();
        check("same_cycle", msr, 8'hC2);
        read_msr();
        check("clear2", msr, 8'hC0);

        // Trailing edge of RI sets te_ri, interrupt follows one cycle later.
        msi_en = 1'b1;
        ri_n = 1'b1;
        tick(7);
        check("te_ri", msr, 8'h84);
        check("irq_early", {7'd0, irq}, 8'h00);
        tick(1);
        check("irq_set", {7'd0, irq}, 8'h01);
        read_msr();
        check("te_clr", msr, 8'h80);
        tick(1);
        check("irq_clr", {7'd0, irq}, 8'h00);
        ri_n = 1'b0;
        tick(7);
        check("ri_rise_no_te", msr, 8'hC0);
        tick(1);
        check("irq_none", {7'd0, irq}, 8'h00);

        msi_en = 1'b0;
        cts_n = 1'b0; dsr_n = 1'b0;
        tick(8);
        read_msr();
        check("restore", msr, 8'hF0);

        // Auto flow control with hysteresis.
        mcr = 6'b100011; rx_level = 5'd13;
        tick(1);
        check("flow_rts_on", {7'd0, rts_n}, 8'h00);
        check("flow_dtr", {7'd0, dtr_n}, 8'h00);
        check("flow_tx", {7'd0, tx_allow}, 8'h01);
        rx_level = 5'd14;
        tick(1);
        check("lvl14", {7'd0, rts_n}, 8'h01);
        rx_level = 5'd9;
        tick(1);
        check("lvl9", {7'd0, rts_n}, 8'h01);
        rx_level = 5'd8;
        tick(1);
        check("lvl8", {7'd0, rts_n}, 8'h00);

        // CTS gating of TX and bypass when auto-flow is off.
        cts_n = 1'b1;
        tick(7);
        check("tx_gated", {7'd0, tx_allow}, 8'h00);
        mcr = 6'b000011;
        #1;
        check("tx_noafe", {7'd0, tx_allow}, 8'h01);
        rx_level = 5'd15;
        tick(1);
        check("fsm_held", {7'd0, rts_n}, 8'h00);
        cts_n = 1'b0;
        rx_level = 5'd0;
        tick(8);
        read_msr();
        check("restore2", msr, 8'hF0);

        // Internal loopback: afe, loop, out2, rts.
        mcr = 6'b111010;
        tick(1);
        check("loop_msr", msr, 8'h96);
        check("loop_rts", {7'd0, rts_n}, 8'h01);
        check("loop_dtr", {7'd0, dtr_n}, 8'h01);
        check("loop_tx", {7'd0, tx_allow}, 8'h01);
        cts_n = 1'b1;
        tick(5);
        cts_n = 1'b0;
        tick(2);
        cts_n = 1'b1;
        tick(10);
        check("loop_ignore", msr, 8'h96);
        mcr = 6'b000000;
        tick(1);
        check("loop_exit", msr, 8'hE7);

        // Reset in the middle of operation.
        msi_en = 1'b1;
        tick(2);
        check("pre_rst_irq", {7'd0, irq}, 8'h01);
        rst = 1'b1;
        tick(1);
        check("mid_rst_msr", msr, 8'h00);
        check("mid_rst_irq", {7'd0, irq}, 8'h00);
        check("mid_rst_rts", {7'd0, rts_n}, 8'h01);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
